multdiv_engine: RTL

MULTDIV_ENGINE -- requirements
Module: multdiv_engine

---
 rtl/multdiv_pkg.sv | 25 ++
 rtl/multdiv_counter.sv | 29 ++
 rtl/multdiv_engine.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared sizing constants, FSM state encoding and a small arithmetic helper
// for the iterative signed multiply/divide engine.
package multdiv_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;
    localparam int COUNT_W    = 6;

    // Counter value during which the final iteration is performed.
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Unsigned magnitude of a two's-complement value; 0x80000000 maps to
    // itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value);
        return value[WIDTH-1] ? (-value) : value;
    endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for the multiply/divide engine: synchronous clear,
// count enable, and a flag marking the final iteration.
module multdiv_counter
    import multdiv_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [COUNT_W-1:0] count,
    output logic               terminal
);

    // Count register: clear has priority over enable, otherwise hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= {COUNT_W{1'b0}};
        end else if (clear) begin
            count <= {COUNT_W{1'b0}};
        end else if (enable) begin
            count <= count + 6'd1;
        end else begin
            count <= count;
        end
    end

    assign terminal = (count == LAST_COUNT);

endmodule

// File: rtl/multdiv_engine.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring on
// magnitudes with sign correction). One iteration per clock, 32 iterations,
// result and exception registered on entry to DONE.
module multdiv_engine
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t state;
    state_t next_state;

    logic start_mult;
    logic start_div;
    logic start_any;
    logic running;
    logic finishing;

    logic [COUNT_W-1:0] count;
    logic               terminal;

    // Booth multiplier: {mul_hi, mul_lo, mul_qm1} is the shifting product.
    logic [WIDTH:0]   mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] mul_m;
    logic             mul_qm1;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   mul_hi_nxt;
    logic [WIDTH-1:0] mul_lo_nxt;
    logic [WIDTH:0]   mul_upper;
    logic             mul_ovf;

    // Non-restoring divider: partial remainder is two bits wider than the
    // divisor so the shifted value plus/minus the divisor never wraps.
    logic [WIDTH+1:0] div_rem;
    logic [WIDTH+1:0] div_shift;
    logic [WIDTH+1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_quo_nxt;
    logic [WIDTH-1:0] div_den;
    logic             div_neg;
    logic             div_zero;
    logic             div_ovf;

    logic [WIDTH-1:0] fin_result;
    logic             fin_exception;

    // A multiply request wins when both start pulses arrive together.
    assign start_mult = ctrl_MULT;
    assign start_div  = ctrl_DIV & ~ctrl_MULT;
    assign start_any  = start_mult | start_div;
    assign running    = (state == MULT) || (state == DIV);
    assign finishing  = running && terminal && !start_any;

    multdiv_counter u_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (start_any),
        .enable   (running && !start_any),
        .count    (count),
        .terminal (terminal)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a start from any state restarts; a counter found
    // beyond the last iteration drops back to IDLE rather than running on.
    always_comb begin
        next_state = state;
        if (start_mult) begin
            next_state = MULT;
        end else if (start_div) begin
            next_state = DIV;
        end else begin
            case (state)
                IDLE: next_state = IDLE;
                MULT, DIV: begin
                    if (terminal) begin
                        next_state = DONE;
                    end else if (count > LAST_COUNT) begin
                        next_state = IDLE;
                    end else begin
                        next_state = state;
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // One Booth step: add/subtract the multiplicand, then arithmetic shift.
    always_comb begin
        booth_sum = mul_hi;
        case ({mul_lo[0], mul_qm1})
            2'b01:   booth_sum = mul_hi + {mul_m[WIDTH-1], mul_m};
            2'b10:   booth_sum = mul_hi - {mul_m[WIDTH-1], mul_m};
            default: booth_sum = mul_hi;
        endcase
        mul_hi_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        mul_lo_nxt = {booth_sum[0], mul_lo[WIDTH-1:1]};
        // Bits 63..31 of the 64-bit product must all match to fit 32 bits.
        mul_upper  = {mul_hi_nxt[WIDTH-1:0], mul_lo_nxt[WIDTH-1]};
        mul_ovf    = !((&mul_upper) || (~|mul_upper));
    end

    // One non-restoring step: shift in next dividend bit, add or subtract
    // divisor depending on remainder sign, quotient bit is the new sign's inverse.
    always_comb begin
        div_shift = {div_rem[WIDTH:0], div_quo[WIDTH-1]};
        if (div_rem[WIDTH+1]) begin
            div_rem_nxt = div_shift + {2'b00, div_den};
        end else begin
            div_rem_nxt = div_shift - {2'b00, div_den};
        end
        div_quo_nxt = {div_quo[WIDTH-2:0], ~div_rem_nxt[WIDTH+1]};
    end

    // Final result selection applied on the last iteration.
    always_comb begin
        fin_result    = {WIDTH{1'b0}};
        fin_exception = 1'b0;
        if (state == MULT) begin
            fin_result    = mul_lo_nxt;
            fin_exception = mul_ovf;
        end else if (div_zero) begin
            fin_result    = {WIDTH{1'b0}};
            fin_exception = 1'b1;
        end else begin
            fin_result    = div_neg ? (-div_quo_nxt) : div_quo_nxt;
            fin_exception = div_ovf;
        end
    end

    // Datapath registers: load operands on a start, iterate while running.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mul_hi   <= {(WIDTH+1){1'b0}};
            mul_lo   <= {WIDTH{1'b0}};
            mul_m    <= {WIDTH{1'b0}};
            mul_qm1  <= 1'b0;
            div_rem  <= {(WIDTH+2){1'b0}};
            div_quo  <= {WIDTH{1'b0}};
            div_den  <= {WIDTH{1'b0}};
            div_neg  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (start_any) begin
            mul_hi   <= {(WIDTH+1){1'b0}};
            mul_lo   <= data_operandB;
            mul_m    <= data_operandA;
            mul_qm1  <= 1'b0;
            div_rem  <= {(WIDTH+2){1'b0}};
            div_quo  <= magnitude(data_operandA);
            div_den  <= magnitude(data_operandB);
            div_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == 32'h0000_0000);
            div_ovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        end else if (running) begin
            mul_hi  <= mul_hi_nxt;
            mul_lo  <= mul_lo_nxt;
            mul_qm1 <= mul_lo[0];
            div_rem <= div_rem_nxt;
            div_quo <= div_quo_nxt;
        end else begin
            mul_hi  <= mul_hi;
            mul_lo  <= mul_lo;
            mul_qm1 <= mul_qm1;
            div_rem <= div_rem;
            div_quo <= div_quo;
        end
    end

    // Result registers change only when an operation completes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_result    <= {WIDTH{1'b0}};
            data_exception <= 1'b0;
        end else if (finishing) begin
            data_result    <= fin_result;
            data_exception <= fin_exception;
        end else begin
            data_result    <= data_result;
            data_exception <= data_exception;
        end
    end

    // Both status outputs decode the state register directly.
    assign data_resultRDY = (state == DONE);
    assign busy           = (state != IDLE);

endmodule
